// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, digit type and the hex/BCD glyph encoder.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {g,f,e,d,c,b,a}, active-high; non-decimal codes collapse to a dash unless hex_mode
  function automatic logic [6:0] seg7_encode(input digit_t digit, input logic hex_mode);
    logic [6:0] seg;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
      default: seg = hex_mode ? SEG_F : SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational single-digit seven-segment decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t     i_digit,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_encode(i_digit, i_hex_mode);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-cathode display driver: latches packed digits on load and
// scans one digit per REFRESH_DIV cycles with registered one-hot enable and segments.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              segment7,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_frame;

  logic                  w_tc;
  logic                  w_last;
  logic [PW-1:0]         w_presc_d;
  logic [IW-1:0]         w_idx_d;
  logic [NUM_DIGITS-1:0] w_zero_from;
  digit_t                w_digit;
  logic                  w_blank;
  logic [6:0]            w_seg;
  logic                  w_run;

  assign w_tc      = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_last    = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_presc_d = w_tc ? '0 : r_presc + 1'b1;
  assign w_idx_d   = !w_tc ? r_idx : (w_last ? '0 : r_idx + 1'b1);

  // Outputs follow the next index so the enable moves on the edge that ends tc
  always_comb begin
    w_zero_from = '0;
    w_digit     = '0;
    w_blank     = 1'b0;
    w_run       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run          = w_run & (r_disp[4*k +: 4] == 4'h0);
      w_zero_from[k] = w_run;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_d == IW'(k)) begin
        w_digit = r_disp[4*k +: 4];
        w_blank = blank_lz && (k != 0) && w_zero_from[k];
      end
    end
  end

  seg7_decode u_decode (
    .i_digit    (w_digit),
    .i_hex_mode (hex_mode),
    .o_seg      (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
      r_seg   <= SEG_BLANK;
      r_en    <= '0;
      r_frame <= 1'b0;
    end else begin
      r_presc <= w_presc_d;
      r_idx   <= w_idx_d;
      if (load) begin
        r_disp <= bcd_in;
      end
      r_seg   <= w_blank ? SEG_BLANK : w_seg;
      r_en    <= NUM_DIGITS'(1) << w_idx_d;
      r_frame <= w_tc && w_last;
    end
  end

  assign segment7   = r_seg;
  assign digit_en   = r_en;
  assign frame_done = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Drives a 4-digit/div-4 and a 1-digit/div-1 instance in lockstep against a cycle-count model.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        hex_mode;
  logic        blank_lz;

  logic [6:0]  seg_a;
  logic [3:0]  en_a;
  logic        fr_a;
  logic [6:0]  seg_b;
  logic [0:0]  en_b;
  logic        fr_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since release (-1 while held in reset) and latched value
  int          t_a, t_b;
  int unsigned disp_a, disp_b;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .segment7   (seg_a),
    .digit_en   (en_a),
    .frame_done (fr_a)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in[3:0]),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .segment7   (seg_b),
    .digit_en   (en_b),
    .frame_done (fr_b)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int unsigned d, input logic hx);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      10: return hx ? 7'h77 : 7'h40;
      11: return hx ? 7'h7C : 7'h40;
      12: return hx ? 7'h39 : 7'h40;
      13: return hx ? 7'h5E : 7'h40;
      14: return hx ? 7'h79 : 7'h40;
      default: return hx ? 7'h71 : 7'h40;
    endcase
  endfunction

  // Expected outputs after the coming edge, from the spec's arithmetic view of the scan
  task automatic model(input int nd, input int div, inout int t, inout int unsigned disp,
                       output int unsigned e_seg, output int unsigned e_en,
                       output int unsigned e_fr);
    int k;
    if (rst) begin
      t = -1; disp = 0; e_seg = 0; e_en = 0; e_fr = 0;
    end else begin
      t     = t + 1;
      k     = ((t + 1) / div) % nd;
      e_en  = 1 << k;
      e_fr  = (((t + 1) % (nd * div)) == 0) ? 1 : 0;
      if (k > 0 && blank_lz && (disp >> (4 * k)) == 0) e_seg = 0;
      else e_seg = glyph((disp >> (4 * k)) & 15, hex_mode);
      if (load) disp = bcd_in & ((1 << (4 * nd)) - 1);
    end
  endtask

  task automatic step();
    int unsigned sa, ea, fa, sb, eb, fb;
    model(4, 4, t_a, disp_a, sa, ea, fa);
    model(1, 1, t_b, disp_b, sb, eb, fb);
    @(posedge clk);
    #1;
    check_eq("seg_a", seg_a, sa);
    check_eq("en_a", en_a, ea);
    check_eq("frame_a", fr_a, fa);
    check_eq("seg_b", seg_b, sb);
    check_eq("en_b", en_b, eb);
    check_eq("frame_b", fr_b, fb);
    load = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic load_and_run(input logic [15:0] v, input logic hx, input logic blz,
                              input int n);
    hex_mode = hx;
    blank_lz = blz;
    bcd_in   = v;
    load     = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned v;
    int z;
    rst = 1'b1; load = 1'b0; bcd_in = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    t_a = -1; t_b = -1; disp_a = 0; disp_b = 0;
    #1;
    rst = 1'b1; step();
    rst = 1'b1; step();
    for (int i = 0; i < 20; i++) step();
    load_and_run(16'h1234, 1'b0, 1'b0, 16);
    load_and_run(16'h00A7, 1'b0, 1'b1, 16);
    load_and_run(16'h00A7, 1'b1, 1'b1, 16);
    load_and_run(16'h0000, 1'b0, 1'b1, 16);
    load_and_run(16'hF05C, 1'b1, 1'b1, 16);
    // load landing exactly on the prescaler terminal cycle
    for (int i = 0; i < 8 && ((t_a + 2) % 4) != 0; i++) step();
    bcd_in = 16'h9876; load = 1'b1; step();
    for (int i = 0; i < 6; i++) step();
    // reset while digit 2 is showing
    for (int i = 0; i < 20 && ((((t_a + 1) / 4) % 4) != 2); i++) step();
    step();
    rst = 1'b1; step();
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 800; i++) begin
      v = $urandom_range(0, 65535);
      z = $urandom_range(0, 4);
      bcd_in   = 16'(v & (32'hFFFF >> (4 * z)));
      load     = ($urandom_range(0, 3) == 0);
      hex_mode = $urandom_range(0, 1) == 1;
      blank_lz = $urandom_range(0, 1) == 1;
      rst      = ($urandom_range(0, 79) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-cathode seven-segment digits. It latches a packed multi-digit BCD/hex value on a load strobe and scans the digits one at a time at a programmable refresh rate. Per digit it drives a one-hot digit enable and a registered segment pattern, with optional hex display, invalid-BCD marking and leading-zero blanking. It sits between the counter/datapath logic that produces BCD results and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be at least 1.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; must be at least 1.

Ports:
- clk  in  1  rising-edge system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe that captures bcd_in into the display register.
- bcd_in  in  4*NUM_DIGITS  packed digits; [3:0] is digit 0, the least significant.
- hex_mode  in  1  1 = show 10–15 as A b C d E F; 0 = show 10–15 as a dash.
- blank_lz  in  1  1 = blank leading zeros.
- segment7  out  7  {g,f,e,d,c,b,a}, active-high, registered.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select, registered.
- frame_done  out  1  one-cycle pulse each time the scan wraps back to digit 0.

## Operation
- Display register: NUM_DIGITS×4 bits.
  - Reset value is 0.
  - Loaded from bcd_in on any cycle with load=1.
  - Holds its value otherwise.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. The cycle where it equals REFRESH_DIV-1 is the terminal cycle (tc).
- Digit index: 0..NUM_DIGITS-1.
  - Advances on tc.
  - Wraps from NUM_DIGITS-1 to 0.
  - Scan order is 0, 1, …, NUM_DIGITS-1, 0, ….
- Decode, as an active-high pattern:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - With hex_mode=1: A→77, b→7C, C→39, d→5E, E→79, F→71.
  - With hex_mode=0: 10–15 → 40 (dash, segment g only).
- Leading-zero blanking: digit k (k≥1) shows 00 when blank_lz=1 and display digits k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked, so the value 0 shows a single "0".
- Outputs are registered from the current index and the current display register. hex_mode and blank_lz are sampled combinationally each cycle; they are not latched.
- digit_en is always exactly one-hot, except during reset.

## Timing
- During rst=1 and on the first edge with rst=1:
  - prescaler = 0, index = 0, display register = 0.
  - segment7 = 00, digit_en = 0, frame_done = 0.
- First cycle after rst is released:
  - digit_en = 1 (digit 0).
  - segment7 = 3F, or the pattern for display digit 0 at that time.
- Each digit stays enabled for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS×REFRESH_DIV cycles.
- Index change on tc: digit_en and segment7 change on the edge following tc.
- frame_done: asserted in the same cycle that digit_en returns to digit 0. It is not asserted for the first digit-0 period after reset.
- Load latency: the value loaded at edge N appears on segment7 at edge N+1 if that digit is currently enabled. There is no frame synchronisation, so tearing within one frame is accepted.
- load coincident with tc: the newly enabled digit shows the newly loaded data one cycle late. The first cycle shows the old data for that digit; from the next cycle on it shows the new data.
- rst asserted mid-scan: all state returns to reset values on that edge, and the scan restarts at digit 0.
- NUM_DIGITS=1: digit_en is constantly 1 after reset, and frame_done pulses every REFRESH_DIV cycles.
- REFRESH_DIV=1: index advances every cycle.

## Structure
- Package seg7_pkg:
  - Segment constants SEG_0..SEG_F, SEG_DASH (7'h40) and SEG_BLANK (7'h00).
  - Digit type logic [3:0].
  - Function seg7_encode(digit, hex_mode).
- Sub-module seg7_decode: combinational 4-bit-plus-hex_mode to 7-bit decoder. It is instantiated once and fed through the index mux. It is the replacement for the earlier single-digit decoder.
- Top level holds the prescaler, index counter, display register, blanking logic and output registers.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=4 unless noted.
- Reset release with no load → digit_en cycles 1,2,4,8 for 4 cycles each; segment7=3F throughout with blank_lz=0; first frame_done 16 cycles after release.
- Load 0x1234 with hex_mode=0, blank_lz=0 → segment7 per digit 0..3 = 66, 4F, 5B, 06.
- Load 0x00A7 with blank_lz=1:
  - hex_mode=0 → 07, 40, 00, 00.
  - hex_mode=1 → 07, 77, 00, 00.
- Load 0x0000 with blank_lz=1 → 3F, 00, 00, 00; digit_en still scans all four digits.
- Assert rst during digit 2 → next cycle outputs 0; after release, scan restarts at digit_en=1 with the display register cleared.
- Corner parameters:
  - NUM_DIGITS=1, REFRESH_DIV=1 → digit_en stuck at 1; frame_done high every cycle after the first.
  - load coincident with tc → one cycle of old data on the new digit, then new data.
